// File: rtl/obs_capture_pkg.sv
// Shared types and constants for the observation capture block.
// Entry layout is fixed at OBS_DW data bits; obs_capture's DW parameter must match it.
package obs_capture_pkg;

    localparam int OBS_DW = 128;

    localparam logic [127:0] MISR_POLY = 128'h87;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0]       step;
        logic [OBS_DW-1:0] data;
    } entry_t;

endpackage

// File: rtl/obs_fifo.sv
// First-word-fall-through FIFO with extended-pointer full/empty detection.
// The head output holds the last popped word while the FIFO is empty.
module obs_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 160
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] hold_q;
    logic         do_pop;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            hold_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold_q <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

    // Storage needs no reset: an empty FIFO always presents hold_q instead.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = empty ? hold_q : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/obs_capture.sv
// Captures {step, data} on observe strobes during an armed run and drains them via valid/ready.
// Optional MISR signature output enabled by defining OBS_CAPTURE_SIG_EN.
module obs_capture
    import obs_capture_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int MAX_CAPT = 30,
    parameter int DW       = OBS_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arm,
    input  logic          obs,
    input  logic [DW-1:0] data,
    input  logic [31:0]   step,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic [31:0]   rd_step,
    output logic          busy,
    output logic          done,
`ifdef OBS_CAPTURE_SIG_EN
    output logic [127:0]  sig,
`endif
    output logic [15:0]   capt_cnt,
    output logic [15:0]   ovf_cnt
);

    state_t state_q;
    state_t state_d;
    entry_t wr_entry;
    entry_t rd_entry;
    logic   fifo_full;
    logic   fifo_empty;
    logic   pop;
    logic   push_req;
    logic   push_ok;
    logic   push_rej;
    logic   last_capt;

    assign wr_entry.step = step;
    assign wr_entry.data = data;

    obs_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_ok),
        .pop     (pop),
        .wr_data (wr_entry),
        .rd_data (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign rd_valid = !fifo_empty;
    assign rd_data  = rd_entry.data;
    assign rd_step  = rd_entry.step;
    assign pop      = rd_valid && rd_ready;

    // A same-cycle pop frees the slot, so a full FIFO can still accept the push.
    assign push_req  = (state_q == ARMED) && obs && !arm;
    assign push_ok   = push_req && (!fifo_full || pop);
    assign push_rej  = push_req && fifo_full && !pop;
    assign last_capt = ({1'b0, capt_cnt} + 17'd1) == 17'(MAX_CAPT);

    assign busy = (state_q == ARMED);
    assign done = (state_q == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (arm) state_d = ARMED;
            ARMED:   if (!arm && push_ok && last_capt) state_d = DONE;
            DONE:    if (arm) state_d = ARMED;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            capt_cnt <= '0;
            ovf_cnt  <= '0;
        end else if (arm) begin
            capt_cnt <= '0;
            ovf_cnt  <= '0;
        end else begin
            if (push_ok) begin
                capt_cnt <= capt_cnt + 16'd1;
            end
            if (push_rej && (ovf_cnt != 16'hFFFF)) begin
                ovf_cnt <= ovf_cnt + 16'd1;
            end
        end
    end

`ifdef OBS_CAPTURE_SIG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= '0;
        end else if (arm) begin
            sig <= '0;
        end else if (push_ok) begin
            sig <= {sig[126:0], 1'b0} ^ (sig[127] ? MISR_POLY : 128'h0) ^ data;
        end
    end
`endif

endmodule

// File: tb/tb_obs_capture.sv
// Directed bench for obs_capture: vector table plus hand-written multi-cycle sequences.
// A second instance with MAX_CAPT=4 covers the auto-stop path.
module tb_obs_capture;

    logic         clk;
    logic         rst;
    logic         arm;
    logic         obs;
    logic [127:0] data;
    logic [31:0]  step;
    logic         rd_ready;

    logic         a_rd_valid, b_rd_valid;
    logic [127:0] a_rd_data,  b_rd_data;
    logic [31:0]  a_rd_step,  b_rd_step;
    logic         a_busy,     b_busy;
    logic         a_done,     b_done;
    logic [15:0]  a_capt,     b_capt;
    logic [15:0]  a_ovf,      b_ovf;
`ifdef OBS_CAPTURE_SIG_EN
    logic [127:0] a_sig,      b_sig;
`endif

    int applied;
    int miscompares;

    obs_capture dut_a (
        .clk      (clk),
        .rst      (rst),
        .arm      (arm),
        .obs      (obs),
        .data     (data),
        .step     (step),
        .rd_valid (a_rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (a_rd_data),
        .rd_step  (a_rd_step),
        .busy     (a_busy),
        .done     (a_done),
`ifdef OBS_CAPTURE_SIG_EN
        .sig      (a_sig),
`endif
        .capt_cnt (a_capt),
        .ovf_cnt  (a_ovf)
    );

    obs_capture #(.MAX_CAPT(4)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .arm      (arm),
        .obs      (obs),
        .data     (data),
        .step     (step),
        .rd_valid (b_rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (b_rd_data),
        .rd_step  (b_rd_step),
        .busy     (b_busy),
        .done     (b_done),
`ifdef OBS_CAPTURE_SIG_EN
        .sig      (b_sig),
`endif
        .capt_cnt (b_capt),
        .ovf_cnt  (b_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         arm;
        logic         obs;
        logic [127:0] data;
        logic [31:0]  step;
        logic         rd_ready;
        logic         exp_valid;
        logic [127:0] exp_data;
        logic [31:0]  exp_step;
        logic [15:0]  exp_capt;
        logic [15:0]  exp_ovf;
        logic         exp_busy;
        logic         exp_done;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drives one cycle of inputs, then returns 1 time unit after the rising edge.
    task automatic applyStimulus(input logic a, input logic o, input logic [127:0] d,
                                 input logic [31:0] s, input logic r);
        arm      = a;
        obs      = o;
        data     = d;
        step     = s;
        rd_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        arm      = 1'b0;
        obs      = 1'b0;
        data     = '0;
        step     = '0;
        rd_ready = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic a, input logic o, input int d, input int s,
                                input logic r, input logic ev, input int ed, input int es,
                                input int ec, input int eo, input logic eb, input logic edn);
        vec_t v;
        v.arm       = a;
        v.obs       = o;
        v.data      = 128'(d);
        v.step      = 32'(s);
        v.rd_ready  = r;
        v.exp_valid = ev;
        v.exp_data  = 128'(ed);
        v.exp_step  = 32'(es);
        v.exp_capt  = 16'(ec);
        v.exp_ovf   = 16'(eo);
        v.exp_busy  = eb;
        v.exp_done  = edn;
        return v;
    endfunction

    initial begin
        applied     = 0;
        miscompares = 0;

        //          arm obs data step rdy | valid data step capt ovf busy done
        vecs[0] = mk(1, 0,  0,  0, 1,  0,  0,  0, 0, 0, 1, 0);
        vecs[1] = mk(0, 1,  1,  1, 1,  1,  1,  1, 1, 0, 1, 0);
        vecs[2] = mk(0, 1,  2,  2, 1,  1,  2,  2, 2, 0, 1, 0);
        vecs[3] = mk(0, 1,  3,  3, 1,  1,  3,  3, 3, 0, 1, 0);
        vecs[4] = mk(0, 0,  0,  0, 1,  0,  3,  3, 3, 0, 1, 0);
        vecs[5] = mk(1, 1,  9,  9, 1,  0,  3,  3, 0, 0, 1, 0);
        vecs[6] = mk(0, 1, 10, 10, 0,  1, 10, 10, 1, 0, 1, 0);
        vecs[7] = mk(0, 0,  0,  0, 0,  1, 10, 10, 1, 0, 1, 0);

        // Reset state
        doReset();
        checkOutput("rst.valid", 128'(a_rd_valid), 128'(0));
        checkOutput("rst.data",  a_rd_data,        128'(0));
        checkOutput("rst.step",  128'(a_rd_step),  128'(0));
        checkOutput("rst.busy",  128'(a_busy),     128'(0));
        checkOutput("rst.done",  128'(a_done),     128'(0));
        checkOutput("rst.capt",  128'(a_capt),     128'(0));
        checkOutput("rst.ovf",   128'(a_ovf),      128'(0));

        // Basic capture, in-order reads, hold-while-empty, restart on arm
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].arm, vecs[i].obs, vecs[i].data, vecs[i].step, vecs[i].rd_ready);
            checkOutput($sformatf("v%0d.valid", i), 128'(a_rd_valid), 128'(vecs[i].exp_valid));
            checkOutput($sformatf("v%0d.data", i),  a_rd_data,        vecs[i].exp_data);
            checkOutput($sformatf("v%0d.step", i),  128'(a_rd_step),  128'(vecs[i].exp_step));
            checkOutput($sformatf("v%0d.capt", i),  128'(a_capt),     128'(vecs[i].exp_capt));
            checkOutput($sformatf("v%0d.ovf", i),   128'(a_ovf),      128'(vecs[i].exp_ovf));
            checkOutput($sformatf("v%0d.busy", i),  128'(a_busy),     128'(vecs[i].exp_busy));
            checkOutput($sformatf("v%0d.done", i),  128'(a_done),     128'(vecs[i].exp_done));
        end

        // Auto-stop at MAX_CAPT=4 on instance B
        doReset();
        applyStimulus(1, 0, 0, 0, 1);
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(0, 1, 128'(i), 32'(i), 1);
            if (i == 3) begin
                checkOutput("stop.done3", 128'(b_done), 128'(0));
            end
            if (i == 4) begin
                checkOutput("stop.done4", 128'(b_done), 128'(1));
                checkOutput("stop.busy4", 128'(b_busy), 128'(0));
                checkOutput("stop.capt4", 128'(b_capt), 128'(4));
            end
        end
        checkOutput("stop.capt6", 128'(b_capt), 128'(4));
        checkOutput("stop.ovf6",  128'(b_ovf),  128'(0));
        checkOutput("stop.done6", 128'(b_done), 128'(1));
        applyStimulus(1, 1, 128'(7), 32'(7), 0);
        checkOutput("stop.rearm.busy", 128'(b_busy), 128'(1));
        checkOutput("stop.rearm.capt", 128'(b_capt), 128'(0));

        // Overflow with consumer stalled, then drain exactly DEPTH entries
        doReset();
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(0, 1, 128'(i), 32'(i), 0);
            if (i == 8) begin
                checkOutput("ovf.capt8", 128'(a_capt), 128'(8));
                checkOutput("ovf.ovf8",  128'(a_ovf),  128'(0));
            end
        end
        checkOutput("ovf.capt10", 128'(a_capt), 128'(8));
        checkOutput("ovf.ovf10",  128'(a_ovf),  128'(2));
        for (int i = 1; i <= 8; i++) begin
            checkOutput($sformatf("drain%0d.valid", i), 128'(a_rd_valid), 128'(1));
            checkOutput($sformatf("drain%0d.step", i),  128'(a_rd_step),  128'(i));
            checkOutput($sformatf("drain%0d.data", i),  a_rd_data,        128'(i));
            applyStimulus(0, 0, 0, 0, 1);
        end
        checkOutput("drain.empty", 128'(a_rd_valid), 128'(0));
        checkOutput("drain.hold",  128'(a_rd_step),  128'(8));

        // Full FIFO accepts a push when a pop happens in the same cycle
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 20; i <= 27; i++) begin
            applyStimulus(0, 1, 128'(i), 32'(i), 0);
        end
        applyStimulus(0, 1, 128'(28), 32'(28), 1);
        checkOutput("fullpop.capt", 128'(a_capt),    128'(9));
        checkOutput("fullpop.ovf",  128'(a_ovf),     128'(0));
        checkOutput("fullpop.head", 128'(a_rd_step), 128'(21));
        applyStimulus(0, 1, 128'(29), 32'(29), 0);
        checkOutput("fullpop.stillfull", 128'(a_ovf), 128'(1));

        // Asynchronous reset with entries queued
        doReset();
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(0, 1, 128'(i), 32'(i), 0);
        end
        checkOutput("amid.pre.capt", 128'(a_capt), 128'(5));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("amid.valid", 128'(a_rd_valid), 128'(0));
        checkOutput("amid.busy",  128'(a_busy),     128'(0));
        checkOutput("amid.capt",  128'(a_capt),     128'(0));
        checkOutput("amid.ovf",   128'(a_ovf),      128'(0));
        checkOutput("amid.step",  128'(a_rd_step),  128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifdef OBS_CAPTURE_SIG_EN
        // Signature: 1, then (1<<1) ^ 2 = 0
        doReset();
        checkOutput("sig.rst", a_sig, 128'(0));
        applyStimulus(1, 0, 0, 0, 1);
        applyStimulus(0, 1, 128'h1, 32'd1, 1);
        checkOutput("sig.first", a_sig, 128'h1);
        applyStimulus(0, 1, 128'h2, 32'd2, 1);
        checkOutput("sig.second", a_sig, 128'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
